// File: rtl/word_path_pkg.sv
// Shared word-path definitions for the UART packer, the async word FIFO
// and the AXI write/verify master.
package word_path_pkg;

  localparam int unsigned DATA_W                = 256;
  localparam int unsigned BYTES_PER_WORD        = 32;
  localparam int unsigned BYTE_IDX_W            = $clog2(BYTES_PER_WORD);
  localparam int unsigned DEFAULT_WORDS_PER_RUN = 32768;  // 1 MiB of 32-byte words

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } packer_state_t;

  // Saturating increment for the 16-bit event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/uart_word_packer_if.sv
// FIFO write port between the word packer (master) and the async FIFO (slave).
interface uart_word_packer_if;
  import word_path_pkg::*;

  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              wr_full;

  modport master (output wr_data, output wr_en, input wr_full);
  modport slave  (input wr_data, input wr_en, output wr_full);

endinterface

// File: rtl/packer_idle_timer.sv
// Idle counter for partial words: restarts on clear, counts while enabled and
// flags expired on its terminal count. A zero timeout never expires.
module packer_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  if (TIMEOUT_CYC == 0) begin : g_off
    assign expired = 1'b0;
  end else begin : g_on
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] count_reg;

    assign expired = enable && (count_reg == TERMINAL);

    // Count idle cycles; clearing wins so the flush cycle also restarts it.
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        count_reg <= '0;
      end else if (enable && !expired) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_word_packer.sv
// Packs UART byte strobes little-endian into 256-bit words and writes them to
// the word FIFO through a one-word hold buffer with full back-pressure.
// Stale partial words are padded on an idle timeout; start is raised once a
// full run of words has been written.
module uart_word_packer
  import word_path_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC   = 1000000,
  parameter logic [7:0]  PAD_BYTE      = 8'h00,
  parameter int unsigned WORDS_PER_RUN = DEFAULT_WORDS_PER_RUN
) (
  input  logic               uart_clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  uart_word_packer_if.master fifo_wr,
  output logic               start,
  output logic [31:0]        word_cnt,
  output logic               overflow,
  output logic [15:0]        drop_cnt,
  output logic [15:0]        pad_cnt
);

  packer_state_t         state_reg;
  logic [BYTE_IDX_W-1:0] byte_idx_reg;
  logic [DATA_W-1:0]     asm_reg;
  logic [DATA_W-1:0]     hold_reg;
  logic                  hold_valid_reg;
  logic [DATA_W-1:0]     wr_data_reg;
  logic                  wr_en_reg;
  logic [31:0]           word_cnt_reg;
  logic                  start_reg;
  logic                  overflow_reg;
  logic [15:0]           drop_cnt_reg;
  logic [15:0]           pad_cnt_reg;

  logic                      in_fill;
  logic                      last_lane;
  logic                      drain;
  logic                      hold_free;
  logic                      expired;
  logic                      word_done;
  logic [BYTES_PER_WORD-1:0] keep_mask;
  logic [DATA_W-1:0]         lane_word;
  logic [DATA_W-1:0]         pad_word;
  logic [DATA_W-1:0]         done_word;

  assign in_fill   = (state_reg == FILL);
  assign last_lane = (byte_idx_reg == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  // Hold empties on any cycle the FIFO is not full; it can then be reloaded
  // on the same edge, so back-to-back words stream without a bubble.
  assign drain     = hold_valid_reg & ~fifo_wr.wr_full;
  assign hold_free = ~hold_valid_reg | drain;
  // Lanes below byte_idx already hold received bytes; the rest get padding.
  assign keep_mask = ~({BYTES_PER_WORD{1'b1}} << byte_idx_reg);

  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
    assign lane_word[gi*8 +: 8] = (byte_idx_reg == BYTE_IDX_W'(gi)) ? rx_data : asm_reg[gi*8 +: 8];
    assign pad_word[gi*8 +: 8]  = keep_mask[gi] ? asm_reg[gi*8 +: 8] : PAD_BYTE;
  end

  // A received byte takes priority over a timeout landing on the same cycle.
  assign word_done = in_fill & ((rx_valid & last_lane) | (~rx_valid & expired));
  assign done_word = rx_valid ? lane_word : pad_word;

  packer_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (uart_clk),
    .rst     (rst),
    .clear   (rx_valid | expired),
    .enable  (in_fill && (byte_idx_reg != '0)),
    .expired (expired)
  );

  // Lane writes, word hand-off into hold (or STALL), and drop/pad accounting.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state_reg      <= FILL;
      byte_idx_reg   <= '0;
      asm_reg        <= '0;
      hold_reg       <= '0;
      hold_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      drop_cnt_reg   <= '0;
      pad_cnt_reg    <= '0;
    end else begin
      if (drain) begin
        hold_valid_reg <= 1'b0;
      end
      case (state_reg)
        FILL: begin
          if (rx_valid) begin
            asm_reg      <= lane_word;
            byte_idx_reg <= last_lane ? '0 : byte_idx_reg + BYTE_IDX_W'(1);
          end else if (expired) begin
            asm_reg      <= pad_word;
            byte_idx_reg <= '0;
            pad_cnt_reg  <= sat_inc16(pad_cnt_reg);
          end
          if (word_done) begin
            if (hold_free) begin
              hold_reg       <= done_word;
              hold_valid_reg <= 1'b1;
            end else begin
              state_reg <= STALL;  // completed word waits in asm_reg
            end
          end
        end
        STALL: begin
          if (hold_free) begin
            hold_reg       <= asm_reg;
            hold_valid_reg <= 1'b1;
            state_reg      <= FILL;
            if (rx_valid) begin
              asm_reg[7:0] <= rx_data;
              byte_idx_reg <= BYTE_IDX_W'(1);
            end
          end else if (rx_valid) begin
            overflow_reg <= 1'b1;
            drop_cnt_reg <= sat_inc16(drop_cnt_reg);
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

  // FIFO write strobe registered off the drain, plus run completion tracking.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      wr_en_reg    <= 1'b0;
      wr_data_reg  <= '0;
      word_cnt_reg <= '0;
      start_reg    <= 1'b0;
    end else begin
      wr_en_reg <= drain;
      if (drain) begin
        wr_data_reg  <= hold_reg;
        word_cnt_reg <= word_cnt_reg + 32'd1;
      end
      if (word_cnt_reg == WORDS_PER_RUN) begin
        start_reg <= 1'b1;
      end
    end
  end

  assign fifo_wr.wr_data = wr_data_reg;
  assign fifo_wr.wr_en   = wr_en_reg;
  assign start           = start_reg;
  assign word_cnt        = word_cnt_reg;
  assign overflow        = overflow_reg;
  assign drop_cnt        = drop_cnt_reg;
  assign pad_cnt         = pad_cnt_reg;

endmodule

// File: doc/uart_word_packer.md
Name: uart_word_packer

Overview:
Byte-to-word assembly stage that sits directly upstream of the async word FIFO feeding the AXI write/verify master. It takes single-cycle byte strobes from the UART receiver and packs 32 bytes, little-endian, into one 256-bit word. It writes each word into the FIFO write port with full back-pressure and a one-word holding buffer. It pads stale partial words on an idle timeout and raises the level `start` that the AXI master synchronises once a full run of words has been delivered.

Parameters:
DATA_W, 256, FIFO word width; must equal 8*BYTES_PER_WORD
BYTES_PER_WORD, 32, bytes per word
TIMEOUT_CYC, 1000000, idle cycles after the last byte before a partial word is padded and flushed; 0 disables padding
PAD_BYTE, 8'h00, fill value for padded byte lanes
WORDS_PER_RUN, 32768, words per run (1 MiB / 32 B); `start` asserts when this count is reached

Ports:
uart_clk  in  1  single clock for the block
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe, rx_data valid
wr_data  out  DATA_W  word to FIFO write port
wr_en  out  1  FIFO write strobe
wr_full  in  1  FIFO full
start  out  1  level, run complete; routed to the AXI master's start input
word_cnt  out  32  words written to FIFO this run
overflow  out  1  sticky, at least one byte dropped
drop_cnt  out  16  bytes dropped, saturating at 16'hFFFF
pad_cnt  out  16  words flushed by timeout, saturating at 16'hFFFF

Behaviour:
- Reset: applied on a uart_clk edge with rst=1. All outputs are 0: wr_data, wr_en, start, word_cnt, overflow, drop_cnt, pad_cnt. byte_idx=0, asm_reg=0, hold_valid=0, FSM=FILL, timer=0. A reset mid-word discards the partial word and any held word.
- Byte lane order: the byte accepted at byte_idx k is written to asm_reg[8k+7:8k]. The first byte lands in [7:0]; the 32nd lands in [255:248].
- FSM state FILL:
  - On rx_valid: write the lane and increment byte_idx.
  - At byte_idx==BYTES_PER_WORD-1 the word completes and byte_idx returns to 0.
  - A completed word moves to hold_reg if hold can take it: hold_valid==0, or hold is draining this same cycle.
  - Otherwise the word stays in asm_reg and the FSM goes to STALL.
- FSM state STALL:
  - The assembled word waits in asm_reg.
  - Any rx_valid is dropped: overflow<=1, drop_cnt++.
  - When hold drains, asm_reg moves to hold on the next cycle and the FSM returns to FILL.
  - A byte arriving in that transfer cycle is accepted into lane 0.
- Hold/output:
  - wr_en = hold_valid & ~wr_full, registered so it is valid in the cycle it asserts. wr_data=hold_reg while wr_en=1.
  - The FIFO is written at most once per cycle.
  - Latency from the 32nd byte strobe to wr_en is 2 cycles when the FIFO is not full.
  - If hold_valid & wr_full, hold keeps its contents, wr_en=0, and hold retries every cycle.
  - A simultaneous drain and load leaves hold_valid=1.
- Timeout:
  - The timer counts while byte_idx!=0 in FILL and resets on every accepted byte.
  - When timer==TIMEOUT_CYC-1: lanes at byte_idx and above are set to PAD_BYTE, the word is treated as complete (same hold/STALL rules), and pad_cnt++.
  - No flush occurs when byte_idx==0.
  - A byte arriving in the timeout cycle is accepted first and restarts the timer; padding does not occur that cycle.
- word_cnt increments on each wr_en. When it reaches WORDS_PER_RUN, start<=1 and stays 1 until rst. Words beyond the run continue to be written and counted.
- start is a level signal; the consumer double-flops it into axi_clk.
- Counters saturate; word_cnt wraps only at 2^32.

Decomposition:
- Shared package (word_path_pkg): DATA_W=256, BYTES_PER_WORD=32, FSM encodings FILL=1'b0 / STALL=1'b1, default WORDS_PER_RUN. The AXI master and FIFO use the same package.
- One sub-module, packer_idle_timer: load/clear/terminal-count counter with parameter TIMEOUT_CYC and output `expired`.
- Lane write, hold buffer and FSM live in the top module.

Test Plan:
- Bytes 0x00..0x1F, one every 4 cycles, wr_full=0 -> exactly one wr_en pulse 2 cycles after the last strobe; wr_data=256'h1F1E...0100; word_cnt=1.
- wr_full=1 held; send 64 bytes back-to-back, then bytes 0x40..0x42 -> word 1 held, word 2 in STALL, 0x40..0x42 dropped, overflow=1, drop_cnt=3. Release wr_full -> two consecutive wr_en pulses in order; byte_idx=0.
- TIMEOUT_CYC=16, PAD_BYTE=8'hA5; send 5 bytes 0x11..0x15 then idle -> 16 cycles after the last byte one word is written: lanes 0-4 = 11..15, lanes 5-31 = A5; pad_cnt=1.
- WORDS_PER_RUN=4; stream 128 bytes -> start rises the cycle after the 4th wr_en and stays 1 while more words follow.
- Assert rst after 10 bytes, release, then send 32 bytes 0x80..0x9F -> the single word written is 0x9F..80 with no old bytes; all counters restart from 0.
- Byte arriving exactly on the timeout cycle (TIMEOUT_CYC=8, 3 bytes, 4th at cycle 7) -> no pad; byte_idx=4; pad_cnt=0.
